// File: rtl/dbm_pkg.sv
// Shared types, width codes and defaults for the data bus master.
package dbm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int         DBM_NUM_SLAVES     = 4;
  localparam logic [3:0] DBM_BASE_REGION    = 4'h1;
  localparam int         DBM_TIMEOUT_CYCLES = 255;

  // Picks the byte/half addressed by off out of a bus word and extends it per func3.
  function automatic logic [31:0] dbm_extend(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [2:0]  func3);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? word[31:16] : word[15:0];
    case (func3)
      F3_B:    dbm_extend = {{24{b[7]}}, b};
      F3_BU:   dbm_extend = {24'b0, b};
      F3_H:    dbm_extend = {{16{h[15]}}, h};
      F3_HU:   dbm_extend = {16'b0, h};
      default: dbm_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/dbm_addr_decoder.sv
// Combinational decode of one access: slave select, misalign/decode error and store strobes.
module dbm_addr_decoder
  import dbm_pkg::*;
#(
  parameter int         NUM_SLAVES  = DBM_NUM_SLAVES,
  parameter logic [3:0] BASE_REGION = DBM_BASE_REGION
) (
  input  logic [3:0]            region,
  input  logic [3:0]            index,
  input  logic [1:0]            offset,
  input  logic [2:0]            func3,
  input  logic                  we,
  output logic [NUM_SLAVES-1:0] slave_sel,
  output logic                  err,
  output logic [3:0]            strb
);

  logic misalign;
  logic decode_err;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    misalign = 1'b0;
    strb     = 4'b0000;
    case (func3)
      F3_B:  strb = 4'b0001 << offset;
      F3_H: begin
        misalign = offset[0];
        strb     = 4'b0011 << {offset[1], 1'b0};
      end
      F3_W: begin
        misalign = |offset;
        strb     = 4'hF;
      end
      // Unsigned widths exist only for loads; as store codes they are undefined.
      F3_BU: misalign = we;
      F3_HU: misalign = we | offset[0];
      default: misalign = 1'b1;
    endcase
    if (!we || misalign) strb = 4'b0000;
  end

  assign decode_err = (region != BASE_REGION) || (int'(index) >= NUM_SLAVES);
  assign err        = misalign | decode_err;

  always_comb begin
    slave_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      slave_sel[i] = !decode_err && (int'(index) == i);
    end
  end

endmodule

// File: rtl/data_bus_master.sv
// Load/store APB-style bus master: decode, SETUP/ACCESS transfer, extended load response.
// Optional ACCESS-phase watchdog is compiled in with `define DBM_TIMEOUT_EN.
module data_bus_master
  import dbm_pkg::*;
#(
  parameter int         NUM_SLAVES     = DBM_NUM_SLAVES,
  parameter logic [3:0] BASE_REGION    = DBM_BASE_REGION,
  parameter int         TIMEOUT_CYCLES = DBM_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [2:0]               req_func3,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     stall,
  output logic                     rsp_valid,
  output logic                     rsp_err,
  output logic [31:0]              rsp_rdata,
  output logic [31:0]              PADDR,
  output logic                     PWRITE,
  output logic [NUM_SLAVES-1:0]    PSEL,
  output logic                     PENABLE,
  output logic [31:0]              PWDATA,
  output logic [3:0]               PSTRB,
  input  logic [NUM_SLAVES*32-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY
);

  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_err;
  logic [3:0]            dec_strb;

  dbm_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_REGION(BASE_REGION)
  ) u_decoder (
    .region   (req_addr[31:28]),
    .index    (req_addr[15:12]),
    .offset   (req_addr[1:0]),
    .func3    (req_func3),
    .we       (req_we),
    .slave_sel(dec_sel),
    .err      (dec_err),
    .strb     (dec_strb)
  );

  state_e                state_q,     state_d;
  logic [3:0]            idx_q,       idx_d;
  logic [1:0]            off_q,       off_d;
  logic [2:0]            func3_q,     func3_d;
  logic [NUM_SLAVES-1:0] psel_q,      psel_d;
  logic                  penable_q,   penable_d;
  logic [31:0]           paddr_q,     paddr_d;
  logic                  pwrite_q,    pwrite_d;
  logic [31:0]           pwdata_q,    pwdata_d;
  logic [3:0]            pstrb_q,     pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic [31:0]           rdata_q,     rdata_d;

  logic [31:0] lane_wdata;
  logic        ready_sel;
  logic [31:0] prdata_sel;
  logic        timeout_hit;

  // Narrow stores are replicated on every lane; PSTRB picks the live ones.
  always_comb begin
    case (req_func3)
      F3_B:    lane_wdata = {4{req_wdata[7:0]}};
      F3_H:    lane_wdata = {2{req_wdata[15:0]}};
      default: lane_wdata = req_wdata;
    endcase
  end

  always_comb begin
    ready_sel  = 1'b0;
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(idx_q) == i) begin
        ready_sel  = PREADY[i];
        prdata_sel = PRDATA[32*i +: 32];
      end
    end
  end

`ifdef DBM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the non-ready ACCESS cycles already spent; the limit-th one ends the transfer.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP)                    cnt_d = '0;
    else if (state_q == ACCESS && !ready_sel) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    off_d       = off_q;
    func3_d     = func3_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = req_addr[15:12];
          off_d   = req_addr[1:0];
          func3_d = req_func3;
          if (dec_err) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rdata_d     = '0;
          end else begin
            state_d  = SETUP;
            psel_d   = dec_sel;
            paddr_d  = {req_addr[31:2], 2'b00};
            pwrite_d = req_we;
            pwdata_d = lane_wdata;
            pstrb_d  = dec_strb;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (ready_sel || timeout_hit) begin
          state_d     = DONE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          if (!ready_sel) begin
            rsp_err_d = 1'b1;
            rdata_d   = '0;
          end else if (!pwrite_q) begin
            rdata_d = dbm_extend(prdata_sel, off_q, func3_q);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      off_q       <= '0;
      func3_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      // NOTE: state updates use <= so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      func3_q     <= func3_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
    end
  end

  // Reset gates the IDLE pass-through so stall is low for the whole reset window.
  assign stall     = (state_q == IDLE) ? (req_valid & ~reset) : (state_q != DONE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rdata_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;

endmodule

// File: tb/tb_data_bus_master.sv
// Self-checking bench for data_bus_master: directed scenarios plus randomized accesses vs a model.
module tb_data_bus_master;

  localparam int NS     = 4;
  localparam int TMO    = 255;
  localparam int BUDGET = 600;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_we;
  logic [2:0]      req_func3;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic            stall;
  logic            rsp_valid;
  logic            rsp_err;
  logic [31:0]     rsp_rdata;
  logic [31:0]     PADDR;
  logic            PWRITE;
  logic [NS-1:0]   PSEL;
  logic            PENABLE;
  logic [31:0]     PWDATA;
  logic [3:0]      PSTRB;
  logic [NS*32-1:0] PRDATA;
  logic [NS-1:0]   PREADY;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_hold;

  always #5 clk = ~clk;

  data_bus_master dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_we   (req_we),
    .req_func3(req_func3),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .stall    (stall),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_rdata(rsp_rdata),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  // Reference: access size, alignment, strobes and extension derived arithmetically.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] word,
                                output logic err, output logic [3:0] strb,
                                output logic [31:0] pwdata, output logic [31:0] ext);
    int     size, off;
    bit     sgn, legal;
    longint v, full;
    off   = int'(addr % 32'd4);
    sgn   = 1'b0;
    legal = 1'b1;
    size  = 1;
    case (f3)
      3'd0:    begin size = 1; sgn = 1'b1; end
      3'd1:    begin size = 2; sgn = 1'b1; end
      3'd2:    size = 4;
      3'd4:    begin size = 1; legal = !we; end
      3'd5:    begin size = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
    err  = !legal || (off % size != 0) || ((addr >> 28) != 32'd1) ||
           (((addr >> 12) & 32'hF) >= 32'(NS));
    strb = (we && !err) ? 4'(((1 << size) - 1) << off) : 4'b0000;
    if (size == 1)      pwdata = (wdata & 32'hFF) * 32'h0101_0101;
    else if (size == 2) pwdata = (wdata & 32'hFFFF) * 32'h0001_0001;
    else                pwdata = wdata;
    full = longint'(1) << (8 * size);
    v    = (longint'(word) >> (8 * off)) % full;
    if (sgn && v >= full / 2) v = v - full;
    ext = 32'(v);
  endfunction

  // Presents one request at the current (mid-cycle) time and follows it to its response.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input int waits, input logic [31:0] word,
                            input bit expect_tmo, input string name);
    logic          e_err, e_rerr, e_en;
    logic [3:0]    e_strb;
    logic [31:0]   e_pw, e_ext, e_rdata;
    logic [NS-1:0] e_sel;
    int            e_lat, cyc, sidx;
    bit            got;
    model(we, f3, addr, wdata, word, e_err, e_strb, e_pw, e_ext);
    sidx  = int'(addr[15:12]);
    e_sel = '0;
    if (sidx < NS) e_sel[sidx] = 1'b1;
    e_rerr = e_err || expect_tmo;
    if (e_err)           begin e_lat = 1;       e_rdata = '0; end
    else if (expect_tmo) begin e_lat = 2 + TMO; e_rdata = '0; end
    else begin
      e_lat   = 3 + waits;
      e_rdata = we ? exp_hold : e_ext;
    end
    req_we    = we;
    req_func3 = f3;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    for (int i = 0; i < NS; i++) begin
      PRDATA[32*i +: 32] = $urandom;
      PREADY[i]          = 1'b1;
    end
    if (sidx < NS) begin
      PRDATA[32*sidx +: 32] = word;
      PREADY[sidx]          = 1'b0;
    end
    #1;
    vectors++;
    if (stall !== 1'b1) $display("FAIL %s stall_on_request: got %b want 1", name, stall);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      if (sidx < NS) PREADY[sidx] = !expect_tmo && (cyc >= 2 + waits);
      #1;
      if (rsp_valid) begin
        got = 1'b1;
        vectors++;
        if (cyc != e_lat) begin
          miscompares++;
          $display("FAIL %s latency: got %0d want %0d", name, cyc, e_lat);
        end
        vectors++;
        if (rsp_err !== e_rerr) begin
          miscompares++;
          $display("FAIL %s rsp_err: got %b want %b", name, rsp_err, e_rerr);
        end
        vectors++;
        if (rsp_rdata !== e_rdata) begin
          miscompares++;
          $display("FAIL %s rsp_rdata: got %h want %h", name, rsp_rdata, e_rdata);
        end
        vectors++;
        if ({stall, PENABLE, PSEL} !== '0) begin
          miscompares++;
          $display("FAIL %s done_bus_idle: got stall=%b penable=%b psel=%b want all 0",
                   name, stall, PENABLE, PSEL);
        end
      end else begin
        vectors++;
        if (stall !== 1'b1) begin
          miscompares++;
          $display("FAIL %s stall_busy: cycle %0d got %b want 1", name, cyc, stall);
        end
        if (!e_err) begin
          e_en = (cyc >= 2);
          vectors++;
          if ({PSEL, PENABLE, PWRITE, PSTRB} !== {e_sel, e_en, we, e_strb}) begin
            miscompares++;
            $display("FAIL %s bus_ctrl: cycle %0d got psel=%b en=%b wr=%b strb=%b want %b %b %b %b",
                     name, cyc, PSEL, PENABLE, PWRITE, PSTRB, e_sel, e_en, we, e_strb);
          end
          vectors++;
          if (PADDR !== {addr[31:2], 2'b00}) begin
            miscompares++;
            $display("FAIL %s paddr: got %h want %h", name, PADDR, {addr[31:2], 2'b00});
          end
          if (we) begin
            vectors++;
            if (PWDATA !== e_pw) begin
              miscompares++;
              $display("FAIL %s pwdata: got %h want %h", name, PWDATA, e_pw);
            end
          end
        end
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s no_response: got none in %0d cycles want cycle %0d", name, BUDGET, e_lat);
    end
    exp_hold = e_rdata;
  endtask

  // One cycle after a response: pulse gone, data held, nothing pending.
  task automatic finish_idle(input string name);
    @(negedge clk);
    #1;
    vectors++;
    if ({rsp_valid, stall} !== 2'b00 || rsp_rdata !== exp_hold) begin
      miscompares++;
      $display("FAIL %s after_done: got valid=%b stall=%b rdata=%h want 0 0 %h",
               name, rsp_valid, stall, rsp_rdata, exp_hold);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_func3 = 3'b010;
    req_addr  = 32'h1000_1000;
    req_wdata = 32'hFFFF_FFFF;
    PRDATA    = '1;
    PREADY    = '1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({stall, rsp_valid, rsp_err, PENABLE, PWRITE, PSEL, PSTRB} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got stall=%b v=%b e=%b en=%b wr=%b psel=%b strb=%b want all 0",
               stall, rsp_valid, rsp_err, PENABLE, PWRITE, PSEL, PSTRB);
    end
    vectors++;
    if ({PADDR, PWDATA, rsp_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h want 0", PADDR, PWDATA, rsp_rdata);
    end
    req_valid = 1'b0;
    @(negedge clk);
    reset    = 1'b0;
    exp_hold = '0;
    #1;
    vectors++;
    if ({stall, PSEL, PENABLE} !== '0) begin
      miscompares++;
      $display("FAIL reset_release: got stall=%b psel=%b en=%b want 0", stall, PSEL, PENABLE);
    end
  endtask

  task automatic test_store_word();
    run_access(1'b1, 3'b010, 32'h1000_1004, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, "sw_word");
    finish_idle("sw_word");
  endtask

  task automatic test_load_byte();
    run_access(1'b0, 3'b000, 32'h1000_2003, 32'hCAFE_F00D, 0, 32'h8012_3456, 1'b0, "lb_sign");
    finish_idle("lb_sign");
    run_access(1'b0, 3'b100, 32'h1000_2003, 32'hCAFE_F00D, 1, 32'h8012_3456, 1'b0, "lbu_zero");
    finish_idle("lbu_zero");
    run_access(1'b0, 3'b001, 32'h1000_3002, 32'h0, 2, 32'h9ABC_1234, 1'b0, "lh_upper");
    finish_idle("lh_upper");
  endtask

  task automatic test_store_half_wait();
    run_access(1'b1, 3'b001, 32'h1000_0002, 32'h0000_1234, 3, 32'h0, 1'b0, "sh_wait3");
    finish_idle("sh_wait3");
    run_access(1'b1, 3'b000, 32'h1000_3001, 32'h0000_00A5, 0, 32'h0, 1'b0, "sb_lane1");
    finish_idle("sb_lane1");
  endtask

  task automatic test_errors();
    run_access(1'b0, 3'b010, 32'h1000_0001, 32'h0, 0, 32'h1111_1111, 1'b0, "lw_misalign");
    finish_idle("lw_misalign");
    run_access(1'b0, 3'b010, 32'h2000_0000, 32'h0, 0, 32'h2222_2222, 1'b0, "bad_region");
    finish_idle("bad_region");
    run_access(1'b1, 3'b000, 32'h1000_5000, 32'h55, 0, 32'h0, 1'b0, "bad_slave");
    finish_idle("bad_slave");
    run_access(1'b0, 3'b011, 32'h1000_1000, 32'h0, 0, 32'h3333_3333, 1'b0, "bad_func3");
    finish_idle("bad_func3");
    run_access(1'b1, 3'b001, 32'h1000_2001, 32'h77, 0, 32'h0, 1'b0, "sh_misalign");
    finish_idle("sh_misalign");
  endtask

  task automatic test_reset_mid_access();
    req_we    = 1'b0;
    req_func3 = 3'b010;
    req_addr  = 32'h1000_3000;
    PREADY    = '0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({PSEL, PENABLE, stall} !== {4'b1000, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_reset_pre: got psel=%b en=%b stall=%b want 1000 1 1", PSEL, PENABLE, stall);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({PSEL, PENABLE, stall, rsp_valid, rsp_err, rsp_rdata} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_now: got psel=%b en=%b stall=%b v=%b rdata=%h want all 0",
               PSEL, PENABLE, stall, rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    reset    = 1'b0;
    exp_hold = '0;
    run_access(1'b0, 3'b101, 32'h1000_3002, 32'h0, 1, 32'hF00D_0BAD, 1'b0, "after_reset");
    finish_idle("after_reset");
  endtask

  task automatic test_done_ignore();
    run_access(1'b0, 3'b010, 32'h1000_0000, 32'h0, 0, 32'h0123_4567, 1'b0, "pre_done");
    req_we    = 1'b1;
    req_func3 = 3'b010;
    req_addr  = 32'h1000_2008;
    req_wdata = 32'h0BAD_CAFE;
    req_valid = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL done_ignore_stall: got %b want 0", stall);
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({PSEL, PENABLE, stall} !== {4'b0000, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL done_ignore_idle: got psel=%b en=%b stall=%b want 0000 0 1", PSEL, PENABLE, stall);
    end
    run_access(1'b1, 3'b010, 32'h1000_2008, 32'h0BAD_CAFE, 0, 32'h0, 1'b0, "held_request");
    finish_idle("held_request");
  endtask

  // Back-to-back random accesses: every request starts the cycle after the previous DONE.
  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    for (int n = 0; n < 80; n++) begin
      we   = 1'($urandom);
      f3   = 3'($urandom);
      addr = $urandom;
      addr[31:28] = ($urandom % 6 == 0) ? 4'h2 : 4'h1;
      addr[15:12] = 4'($urandom_range(0, 5));
      if ($urandom % 2 == 0) addr[1:0] = 2'b00;
      run_access(we, f3, addr, $urandom, $urandom_range(0, 3), $urandom, 1'b0, "random");
      finish_idle("random");
    end
  endtask

`ifdef DBM_TIMEOUT_EN
  task automatic test_timeout();
    run_access(1'b0, 3'b010, 32'h1000_1000, 32'h0, 0, 32'h5555_AAAA, 1'b1, "timeout");
    finish_idle("timeout");
    run_access(1'b0, 3'b010, 32'h1000_1000, 32'h0, 1, 32'h5555_AAAA, 1'b0, "post_timeout");
    finish_idle("post_timeout");
  endtask
`endif

  initial begin
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_func3 = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
    PRDATA    = '0;
    PREADY    = '0;
    exp_hold  = '0;
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half_wait();
    test_errors();
    test_reset_mid_access();
    test_done_ignore();
`ifdef DBM_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
